// File: rtl/fp_subtractor_seq_if.sv
// ---------------------------------------------------------------------------
// fp_subtractor_seq_if
//   Operand/result handshake bundle for fp_subtractor_seq.
//   Signals:
//     x, y       [31:0]  IEEE-754 single operands (result = x - y)
//     in_valid           operands present        (master -> slave)
//     in_ready           slave can accept        (slave  -> master)
//     result     [31:0]  difference              (slave  -> master)
//     out_valid          result valid            (slave  -> master)
//     out_ready          consumer takes result   (master -> slave)
//   Modports: master (producer/consumer side), slave (the subtractor).
// ---------------------------------------------------------------------------
interface fp_subtractor_seq_if;
  logic [31:0] x;
  logic [31:0] y;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output x, y, in_valid, out_ready,
    input  in_ready, result, out_valid
  );

  modport slave (
    input  x, y, in_valid, out_ready,
    output in_ready, result, out_valid
  );
endinterface

// File: rtl/fp_subtractor_seq.sv
// ---------------------------------------------------------------------------
// fp_subtractor_seq
//   Multi-cycle IEEE-754 single-precision subtractor (result = x - y),
//   round toward zero, denormal operands flushed to zero.
//   FSM: IDLE -> ALIGN -> ADD -> NORM -> PACK -> DONE -> IDLE.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   fp_subtractor_seq_if.slave (x, y, in_valid/in_ready,
//           result, out_valid/out_ready)
//   Build option:
//     FP_SUB_FAST_ALIGN_EN  when defined, ALIGN and NORM each take one cycle
//                           (barrel shift + leading-zero count); otherwise
//                           both shift one bit per cycle. Results identical.
// ---------------------------------------------------------------------------
module fp_subtractor_seq (
  input  logic                clk,
  input  logic                rst,
  fp_subtractor_seq_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK, DONE} state_e;

  state_e             state_q;
  logic        [31:0] x_q;          // captured minuend
  logic        [31:0] y_q;          // captured subtrahend, sign already inverted
  logic               sign_b_q;     // operand with the larger exponent
  logic               sign_s_q;     // operand with the smaller exponent
  logic        [26:0] man_b_q;      // hidden + 23 fraction + 3 extension bits
  logic        [26:0] man_s_q;
  logic        [27:0] man_q;        // sum/difference incl. carry-out bit
  logic               sign_r_q;
  logic signed [9:0]  exp_q;        // wide enough to see overflow and underflow
  logic        [7:0]  diff_q;       // remaining alignment distance
  logic        [4:0]  cnt_q;        // alignment shifts performed so far
  logic        [31:0] result_q;
  logic               in_ready_q;
  logic               out_valid_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  // Subtraction becomes addition of -y.
  logic [31:0] neg_y;
  logic        x_big;
  assign neg_y = {~bus.y[31], bus.y[30:0]};
  assign x_big = bus.x[30:23] >= bus.y[30:23];

  // Exponent 0 flushes the operand to zero.
  function automatic logic [26:0] unpack_man(input logic [30:0] f);
    return (f[30:23] == 8'd0) ? 27'd0 : {1'b1, f[22:0], 3'b000};
  endfunction

`ifdef FP_SUB_FAST_ALIGN_EN
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  logic [4:0] norm_lzc;
  assign norm_lzc = lzc27(man_q[26:0]);
`endif

  // Magnitude add/subtract; sign follows the larger magnitude.
  logic [27:0] add_res;
  logic        add_sign;
  always_comb begin
    add_res  = '0;
    add_sign = sign_b_q;
    if (sign_b_q == sign_s_q) begin
      add_res = {1'b0, man_b_q} + {1'b0, man_s_q};
    end else if (man_b_q >= man_s_q) begin
      add_res = {1'b0, man_b_q - man_s_q};
    end else begin
      add_res  = {1'b0, man_s_q - man_b_q};
      add_sign = sign_s_q;
    end
  end

  // Final packing; special operands take priority over the datapath value.
  logic [31:0] pack_res;
  always_comb begin
    pack_res = {sign_r_q, exp_q[7:0], man_q[25:3]};
    if (x_q[30:23] == 8'hFF && y_q[30:23] == 8'hFF) pack_res = 32'h7FC0_0000;
    else if (x_q[30:23] == 8'hFF)                   pack_res = x_q;
    else if (y_q[30:23] == 8'hFF)                   pack_res = y_q;
    else if (man_q == 28'd0)                        pack_res = 32'h0000_0000;
    else if (exp_q >= 10'sd255)                     pack_res = {sign_r_q, 8'hFF, 23'd0};
    else if (exp_q < 10'sd1)                        pack_res = {sign_r_q, 31'd0};
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block sees the pre-edge value of every other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset along with control so an aborted
      // operation leaves nothing stale behind; there is no RAM here.
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sign_b_q    <= 1'b0;
      sign_s_q    <= 1'b0;
      man_b_q     <= '0;
      man_s_q     <= '0;
      man_q       <= '0;
      sign_r_q    <= 1'b0;
      exp_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q   <= bus.x;
            y_q   <= neg_y;
            cnt_q <= '0;
            if (x_big) begin
              sign_b_q <= bus.x[31];
              man_b_q  <= unpack_man(bus.x[30:0]);
              sign_s_q <= neg_y[31];
              man_s_q  <= unpack_man(neg_y[30:0]);
              exp_q    <= {2'b00, bus.x[30:23]};
              diff_q   <= bus.x[30:23] - bus.y[30:23];
            end else begin
              sign_b_q <= neg_y[31];
              man_b_q  <= unpack_man(neg_y[30:0]);
              sign_s_q <= bus.x[31];
              man_s_q  <= unpack_man(bus.x[30:0]);
              exp_q    <= {2'b00, bus.y[30:23]};
              diff_q   <= bus.y[30:23] - bus.x[30:23];
            end
            in_ready_q <= 1'b0;
            state_q    <= ALIGN;
          end
        end
        ALIGN: begin
`ifdef FP_SUB_FAST_ALIGN_EN
          // Shifts of 27 or more clear the mantissa, matching the serial cap.
          man_s_q <= man_s_q >> diff_q;
          state_q <= ADD;
`else
          if (diff_q == 8'd0 || cnt_q == 5'd27) begin
            state_q <= ADD;
          end else begin
            man_s_q <= man_s_q >> 1;
            diff_q  <= diff_q - 8'd1;
            cnt_q   <= cnt_q + 5'd1;
            if (diff_q == 8'd1 || cnt_q == 5'd26) state_q <= ADD;
          end
`endif
        end
        ADD: begin
          man_q    <= add_res;
          sign_r_q <= add_sign;
          state_q  <= NORM;
        end
        NORM: begin
`ifdef FP_SUB_FAST_ALIGN_EN
          if (man_q[27]) begin
            man_q <= man_q >> 1;
            exp_q <= exp_q + 10'sd1;
          end else if (man_q != 28'd0) begin
            man_q <= man_q << norm_lzc;
            exp_q <= exp_q - signed'(10'(norm_lzc));
          end
          state_q <= PACK;
`else
          if (man_q[27]) begin
            man_q   <= man_q >> 1;
            exp_q   <= exp_q + 10'sd1;
            state_q <= PACK;
          end else if (man_q[26] || man_q == 28'd0) begin
            state_q <= PACK;
          end else begin
            man_q <= man_q << 1;
            exp_q <= exp_q - 10'sd1;
          end
`endif
        end
        PACK: begin
          result_q    <= pack_res;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // Returning to IDLE first keeps a new accept out of this cycle.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_subtractor_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_subtractor_seq
//   Self-checking bench for fp_subtractor_seq: directed corner vectors plus
//   random operands, each compared with an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fp_subtractor_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  fp_subtractor_seq_if bus ();

  fp_subtractor_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef FP_SUB_FAST_ALIGN_EN
  localparam int ALIGN_LAT_DELTA = 0;
`else
  localparam int ALIGN_LAT_DELTA = 23;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: signed integer arithmetic on 27-bit scaled mantissas,
  // normalised by scaling until the leading one sits at bit 26.
  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] yv);
    logic [31:0] b;
    int          ea, eb, e, sh;
    longint      ma, mb, s, m;
    logic        neg;
    b  = {~yv[31], yv[30:0]};
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 && eb == 255) return 32'h7FC0_0000;
    if (ea == 255) return a;
    if (eb == 255) return b;
    ma = (ea == 0) ? 64'sd0 : longint'({1'b1, a[22:0]}) * 8;
    mb = (eb == 0) ? 64'sd0 : longint'({1'b1, b[22:0]}) * 8;
    if (ea >= eb) begin
      e = ea; sh = ea - eb;
      if (sh > 27) sh = 27;
      mb = mb >> sh;
    end else begin
      e = eb; sh = eb - ea;
      if (sh > 27) sh = 27;
      ma = ma >> sh;
    end
    if (a[31]) ma = -ma;
    if (b[31]) mb = -mb;
    s = ma + mb;
    if (s == 0) return 32'h0000_0000;
    neg = (s < 0);
    m   = neg ? -s : s;
    if (m >= 64'sd134217728) begin m = m / 2; e++; end
    while (m < 64'sd67108864) begin m = m * 2; e--; end
    if (e >= 255) return {neg, 8'hFF, 23'd0};
    if (e < 1)    return {neg, 31'd0};
    return {neg, 8'(e), 23'(m / 8)};
  endfunction

  // One complete transaction; busy-time noise on x/y/in_valid must be ignored.
  task automatic run_op(input logic [31:0] xv, input logic [31:0] yv,
                        input int hold, output int lat);
    logic [31:0] exp_r, held;
    int          n;
    exp_r = ref_sub(xv, yv);
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.x = xv; bus.y = yv; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      bus.x = $urandom; bus.y = $urandom;
      @(negedge clk);
      n++;
    end
    lat = n;
    bus.in_valid = 1'b0;
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
    held = bus.result;
    check("result", held, exp_r);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_ready", 32'(bus.in_ready), 32'd0);
      check("hold_result", bus.result, held);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    check("ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  logic [31:0] dir_x [10] = '{32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000,
                              32'h7F7F_FFFF, 32'h7F80_0000, 32'h0080_0000,
                              32'h0000_0001, 32'h7F80_0000, 32'h3F80_0000,
                              32'hC120_0000};
  logic [31:0] dir_y [10] = '{32'h3F80_0000, 32'h3F80_0000, 32'hC000_0000,
                              32'hFF7F_FFFF, 32'h7F80_0000, 32'h0080_0001,
                              32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000,
                              32'h4120_0000};
  logic [31:0] specials [4] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h0000_0000};

  initial begin
    int lat_a, lat_b, lat;
    logic [31:0] rx, ry;
    bus.x = '0; bus.y = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst = 1'b0;

    // Directed corners (3-1 held for 3 cycles to show one sustained pulse).
    run_op(dir_x[0], dir_y[0], 3, lat);
    for (int i = 1; i < 10; i++) run_op(dir_x[i], dir_y[i], 0, lat);

    // Exponent difference 24 vs 1, both with a single normalising shift.
    run_op(32'h4B80_0000, 32'h3F80_0000, 0, lat_a);
    run_op(32'h4000_0000, 32'h3F80_0000, 0, lat_b);
    check("align_lat_delta", 32'(lat_a - lat_b), 32'(ALIGN_LAT_DELTA));

    // Back-pressure: 10 cycles held, then exactly one transfer.
    run_op(32'h4120_0000, 32'h3E80_0000, 10, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_second_pulse", 32'(bus.out_valid), 32'd0);
    end

    // Reset in the middle of a long normalisation.
    bus.x = 32'h3F80_0000; bus.y = 32'h3F7F_FFFF; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h3F80_0000, 32'h3F7F_FFFF, 0, lat);

    // Random operands with biased exponent relationships.
    for (int k = 0; k < 300; k++) begin
      rx = $urandom;
      case ($urandom_range(0, 3))
        0: ry = $urandom;
        1: ry = {1'($urandom), 8'(rx[30:23] + 8'($urandom_range(0, 3))), 23'($urandom)};
        2: ry = rx ^ 32'($urandom_range(0, 255));
        default: ry = specials[$urandom_range(0, 3)];
      endcase
      run_op(rx, ry, $urandom_range(0, 2), lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fp_subtractor_seq.md
FP_SUBTRACTOR_SEQ -- requirements
Module: fp_subtractor_seq

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock), then rst input 1 (asynchronous active-high reset).
REQ-002 The module SHALL have the port x: input, 32 bits, IEEE-754 single-precision minuend.
REQ-003 The module SHALL have the port y: input, 32 bits, IEEE-754 single-precision subtrahend.
REQ-004 The module SHALL have the port in_valid: input, 1 bit, operands present.
REQ-005 The module SHALL have the port in_ready: output, 1 bit, block can accept operands.
REQ-006 The module SHALL have the port result: output, 32 bits, x minus y.
REQ-007 The module SHALL have the port out_valid: output, 1 bit, result valid.
REQ-008 The module SHALL have the port out_ready: input, 1 bit, consumer takes result.

Function
REQ-009 The module SHALL use the FSM states IDLE, ALIGN, ADD, NORM, PACK and DONE, and SHALL be in exactly one state per cycle.
REQ-010 in_ready SHALL be 1 only in IDLE; x and y SHALL be captured when in_valid and in_ready are both 1, with y's sign inverted on capture, and the FSM SHALL then go to ALIGN.
REQ-011 Exponent-0 operands SHALL be treated as zero (denormals flushed); the hidden bit SHALL be 1 otherwise; mantissas SHALL be held as 27 bits (hidden, 23 fraction, 3 extension bits).
REQ-012 ALIGN SHALL right-shift the smaller-exponent mantissa one bit per cycle until the exponent difference is consumed or 27 shifts occur, and SHALL last at least 1 cycle.
REQ-013 ADD (1 cycle) SHALL add magnitudes for equal effective signs, else subtract the smaller from the larger; the result sign SHALL be that of the larger magnitude.
REQ-014 NORM SHALL right-shift once on carry-out (exponent +1), else left-shift one bit per cycle until the hidden bit is 1 (exponent -1 each), and SHALL last at least 1 cycle.
REQ-015 PACK (1 cycle) SHALL truncate the 3 extension bits (round toward zero) and form result.
REQ-016 An exact-zero difference SHALL give 0x00000000.
REQ-017 An exponent reaching 255 or more SHALL give signed infinity (exp 255, fraction 0).
REQ-018 An exponent below 1 SHALL give signed zero.
REQ-019 Special operands SHALL be resolved in PACK:
- x and y both exponent 255 → 0x7FC00000;
- only x exponent 255 → x;
- only y exponent 255 → y with its sign flipped.
REQ-020 out_valid SHALL be 1 only in DONE, and result SHALL be held stable while out_valid is 1 and out_ready is 0.
REQ-021 When out_valid and out_ready are both 1, the FSM SHALL return to IDLE the next cycle; no new operand SHALL be accepted in that same cycle.
REQ-022 in_valid asserted while busy SHALL be ignored, and captured operands SHALL be unaffected by later changes of x or y.

Reset
REQ-023 While rst is 1, the FSM SHALL be in IDLE, in_ready SHALL be 1, out_valid SHALL be 0, and result and all internal registers SHALL be 0.
REQ-024 rst asserted in any state, including mid-ALIGN or mid-NORM, SHALL abort the operation immediately with no output pulse; the first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-025 When FP_SUB_FAST_ALIGN_EN is defined, ALIGN and NORM SHALL each complete in exactly 1 cycle using a barrel shifter and leading-zero count, so that accept-to-out_valid latency is fixed at 5 cycles.
REQ-026 When FP_SUB_FAST_ALIGN_EN is undefined, the bit-serial shifting of REQ-012 and REQ-014 SHALL apply and latency SHALL be variable; result values SHALL be bit-identical in both builds.

Verification
REQ-027 Bench scenario: x=0x40400000, y=0x3F800000 → result 0x40000000 (3.0-1.0), one out_valid pulse held until out_ready.
REQ-028 Bench scenario: x=0x3F800000, y=0x3F800000 → result 0x00000000; and x=0x3F800000, y=0xC0000000 → result 0x40400000.
REQ-029 Bench scenario: x=0x7F7FFFFF, y=0xFF7FFFFF → result 0x7F800000; and x=0x7F800000, y=0x7F800000 → result 0x7FC00000.
REQ-030 Bench scenario: x=0x4B800000, y=0x3F800000 (exponent difference 24) → result 0x4B7FFFFF by truncation; in the slow build, ALIGN lasts 24 cycles.
REQ-031 Bench scenario: out_ready held 0 for 10 cycles in DONE → result stable and in_ready 0 throughout; on release, exactly one transfer occurs.
REQ-032 Bench scenario: rst pulsed during NORM → out_valid 0 and in_ready 1 after reset, and the next operation returns the correct result.
